// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: shares one 8-bit slave port between
// NUM_MASTERS masters. The owner keeps the bus for its whole cyc so RMW
// sequences stay atomic. A per-strobe watchdog turns a stalled strobe into
// a one-cycle error to the owner.
module wb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              wb_cyc_o,
  output logic                              wb_stb_o,
  output logic                              wb_we_o,
  output logic [ADDR_WIDTH-1:0]             wb_adr_o,
  output logic [DATA_WIDTH-1:0]             wb_dat_o,
  input  logic [DATA_WIDTH-1:0]             wb_dat_i,
  input  logic                              wb_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // A disabled watchdog still gets a 1-bit counter that never leaves zero.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] adr_a;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] dat_a;
  logic [IW-1:0]                          pick;
  logic                                   found;
  logic                                   timeout_hit;
  int                                     idx;

  // Packed per-master buses map one-to-one onto the flat port vectors.
  assign adr_a   = m_adr_i;
  assign dat_a   = m_dat_i;
  assign grant_o = grant_q;
  assign m_dat_o = wb_dat_i;

  // Round-robin pick: first requester after last_q, wrapping, last_q itself last.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_cyc_i[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Owner muxing; watchdog expiry masks the strobe and replaces ack with err.
  always_comb begin
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    m_ack_o     = '0;
    m_err_o     = '0;
    timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CW'(TIMEOUT_CYCLES));
    if (state_q == OWN) begin
      wb_cyc_o          = m_cyc_i[owner_q];
      wb_stb_o          = m_stb_i[owner_q] & ~timeout_hit;
      wb_we_o           = m_we_i[owner_q];
      wb_adr_o          = adr_a[owner_q];
      wb_dat_o          = dat_a[owner_q];
      m_ack_o[owner_q]  = wb_ack_i & wb_stb_o;
      m_err_o[owner_q]  = timeout_hit;
    end
  end

  // Next state: grant on any request, release only when the owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = OWN;
          owner_d = pick;
          grant_d = NUM_MASTERS'(1) << pick;
        end
      end
      OWN: begin
        if (!m_cyc_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if ((TIMEOUT_CYCLES == 0) || timeout_hit ||
                     !m_stb_i[owner_q] || wb_ack_i) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last_q resets to the top master so master 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter (2 masters, 4-cycle watchdog). Completed
// slave transfers are checked against a queue of expected transactions.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [15:0] m_adr = '0, m_dat = '0;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, grant_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o, wb_dat_o;
  logic [7:0]  wb_dat_i = '0;
  logic        manual_ack = 1'b0, auto_ack = 1'b0;
  wire         wb_ack_i = manual_ack | (auto_ack & wb_stb_o);

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] adr;
    logic       we;
    logic [7:0] dat;
  } exp_t;
  exp_t sb[$];

  logic [1:0] glog[$];
  logic [1:0] gprev;
  int         sent[2];
  logic       acked[2];

  wb_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [7:0] adr, input logic [7:0] dat);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_adr[k*8 +: 8] = adr;
    m_dat[k*8 +: 8] = dat;
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [7:0] adr, input logic we,
                          input logic [7:0] dat);
    exp_t e;
    e.gnt = g; e.adr = adr; e.we = we; e.dat = dat;
    sb.push_back(e);
  endtask

  // Every strobe the slave acknowledges must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_stb_o && wb_ack_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("txn_grant", grant_o, e.gnt);
        chk("txn_adr", wb_adr_o, e.adr);
        chk("txn_we", wb_we_o, e.we);
        chk("txn_ack", m_ack_o, e.gnt);
        if (e.we) chk("txn_wdat", wb_dat_o, e.dat);
        else      chk("txn_rdat", m_dat_o, e.dat);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    rst_n = 1'b1;

    // Both masters, three single writes each, slave acks immediately
    auto_ack = 1'b1;
    gprev = '0;
    sent[0] = 0; sent[1] = 0; acked[0] = 1'b0; acked[1] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (acked[k]) begin
          set_m(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
          acked[k] = 1'b0;
        end else if (!m_cyc[k] && sent[k] < 3) begin
          set_m(k, 1'b1, 1'b1, 1'b1, 8'(32 + k*8 + sent[k]), 8'(80 + k*16 + sent[k]));
          push_exp(2'(1 << k), 8'(32 + k*8 + sent[k]), 1'b1, 8'(80 + k*16 + sent[k]));
          sent[k]++;
        end
      end
      #1;
      for (int k = 0; k < 2; k++) if (m_ack_o[k]) acked[k] = 1'b1;
      if (grant_o !== gprev) glog.push_back(grant_o);
      gprev = grant_o;
    end
    auto_ack = 1'b0;
    chk("t2_log_len", glog.size(), 12);
    for (int i = 0; i < 12 && i < glog.size(); i++)
      chk("t2_grant_seq", glog[i], (i % 2 == 1) ? 0 : (((i / 2) % 2 == 0) ? 1 : 2));

    // Master 0 alone: read 0x42, slave answers 0xA5 two cycles after strobe
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 8'h42, 8'h00);
    push_exp(2'b01, 8'h42, 1'b0, 8'hA5);
    #1;
    chk("t1_pre_grant", grant_o, 0);
    chk("t1_pre_cyc", wb_cyc_o, 0);
    tick();
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_adr", wb_adr_o, 8'h42);
    chk("t1_we", wb_we_o, 0);
    chk("t1_stb", wb_stb_o, 1);
    tick();
    chk("t1_no_ack_yet", m_ack_o, 0);
    tick();
    manual_ack = 1'b1; wb_dat_i = 8'hA5;
    #1;
    chk("t1_ack", m_ack_o, 2'b01);
    chk("t1_rdat", m_dat_o, 8'hA5);
    tick();
    manual_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("t1_ack_1cyc", m_ack_o, 0);
    tick();
    chk("t1_release", grant_o, 0);

    // RMW lock: master 0 read then write 0x10 with a 2-cycle strobe gap
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    push_exp(2'b01, 8'h10, 1'b0, 8'h3C);
    tick();
    chk("t3_grant", grant_o, 2'b01);
    set_m(1, 1'b1, 1'b1, 1'b1, 8'h30, 8'h77);
    tick();
    manual_ack = 1'b1; wb_dat_i = 8'h3C;
    #1;
    chk("t3_rd_ack", m_ack_o, 2'b01);
    tick();
    manual_ack = 1'b0; m_stb[0] = 1'b0;
    #1;
    chk("t3_gap1_grant", grant_o, 2'b01);
    chk("t3_gap1_stb", wb_stb_o, 0);
    tick();
    manual_ack = 1'b1;
    #1;
    chk("t3_gap2_grant", grant_o, 2'b01);
    chk("t3_gap_ack_ignored", m_ack_o, 0);
    tick();
    manual_ack = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h99);
    push_exp(2'b01, 8'h10, 1'b1, 8'h99);
    #1;
    chk("t3_wr_we", wb_we_o, 1);
    tick();
    manual_ack = 1'b1;
    #1;
    chk("t3_wr_ack", m_ack_o, 2'b01);
    tick();
    manual_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("t3_hold", grant_o, 2'b01);
    chk("t3_cyc_drop", wb_cyc_o, 0);
    tick();
    chk("t3_idle_gap", grant_o, 0);
    tick();
    chk("t4_grant_m1", grant_o, 2'b10);

    // Watchdog: master 1 write never acked
    for (int i = 0; i < 4; i++) begin
      chk("t4_stb_vis", wb_stb_o, 1);
      chk("t4_no_err", m_err_o, 0);
      tick();
    end
    manual_ack = 1'b1;
    #1;
    chk("t4_err", m_err_o, 2'b10);
    chk("t4_stb_masked", wb_stb_o, 0);
    chk("t4_ack_discard", m_ack_o, 0);
    tick();
    manual_ack = 1'b0;
    push_exp(2'b10, 8'h30, 1'b1, 8'h77);
    #1;
    chk("t4_retry_stb", wb_stb_o, 1);
    chk("t4_retry_err", m_err_o, 0);
    manual_ack = 1'b1;
    #1;
    chk("t4_retry_ack", m_ack_o, 2'b10);
    tick();
    manual_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("t4_release", grant_o, 0);

    // Stray ack while idle
    manual_ack = 1'b1;
    #1;
    chk("t5_stray_ack", m_ack_o, 0);
    tick();
    chk("t5_stray_grant", grant_o, 0);
    chk("t5_stray_cyc", wb_cyc_o, 0);
    manual_ack = 1'b0;

    // Reset mid-ownership; master 0 owns briefly first so last grant is 0
    set_m(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("t6_pre_grant", grant_o, 2'b01);
    set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    set_m(1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
    tick();
    chk("t6_m1_grant", grant_o, 2'b10);
    chk("t6_m1_stb", wb_stb_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_cyc", wb_cyc_o, 0);
    chk("t6_rst_stb", wb_stb_o, 0);
    set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
    set_m(1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
    tick();
    chk("t6_restart_m0", grant_o, 2'b01);
    set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
